// File: rtl/col_engine_pkg.sv
// Shared types and row helpers for the drum-mesh column engine.
// Row wrap helper is used by the sequencer and the read-address path.
package col_engine_pkg;

    typedef enum logic [2:0] {
        ST_INIT    = 3'd0,
        ST_IDLE    = 3'd1,
        ST_PRIME   = 3'd2,
        ST_READ    = 3'd3,
        ST_COMPUTE = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    localparam int ROW_BOTTOM      = 0;
    localparam int ROW_TOP_DEFAULT = 29;
    localparam int PULSE_W         = 1;

    function automatic int wrap_next(input int row,
                                     input int top = ROW_TOP_DEFAULT);
        return (row >= top) ? ROW_BOTTOM : row + 1;
    endfunction

endpackage

// File: rtl/col_row_sequencer.sv
// Row counter and state machine for one mesh column.
// INIT writes are held off for one cycle after reset release.
module col_row_sequencer
    import col_engine_pkg::*;
#(
    parameter int R  = 30,
    parameter int AW = $clog2(R)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          init_req_i,
    input  logic          step_go_i,
    output state_t        state_o,
    output logic [AW-1:0] row_o,
    output logic          init_wr_o
);

    localparam int ROW_TOP = R - 1;

    state_t        state_q, state_d;
    logic [AW-1:0] row_q, row_d;
    logic          arm_q;
    logic          at_top;
    logic          busy_step;

    assign at_top    = int'(row_q) == ROW_TOP;
    assign busy_step = (state_q == ST_PRIME) || (state_q == ST_READ) ||
                       (state_q == ST_COMPUTE);
    assign state_o   = state_q;
    assign row_o     = row_q;
    assign init_wr_o = (state_q == ST_INIT) && arm_q;

    // Next state and row; an init request aborts a running step.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        unique case (state_q)
            ST_INIT: begin
                if (arm_q) begin
                    if (at_top) begin
                        state_d = ST_IDLE;
                        row_d   = '0;
                    end else begin
                        row_d = AW'(wrap_next(int'(row_q), ROW_TOP));
                    end
                end
            end
            ST_IDLE: begin
                row_d = '0;
                if (init_req_i) begin
                    state_d = ST_INIT;
                end else if (step_go_i) begin
                    state_d = ST_PRIME;
                end
            end
            ST_PRIME: begin
                row_d   = '0;
                state_d = ST_READ;
            end
            ST_READ: begin
                state_d = ST_COMPUTE;
            end
            ST_COMPUTE: begin
                if (at_top) begin
                    state_d = ST_DONE;
                    row_d   = '0;
                end else begin
                    state_d = ST_READ;
                    row_d   = AW'(wrap_next(int'(row_q), ROW_TOP));
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                row_d   = '0;
            end
            default: begin
                state_d = ST_INIT;
                row_d   = '0;
            end
        endcase
        if (busy_step && init_req_i) begin
            state_d = ST_INIT;
            row_d   = '0;
        end
    end

    // State, row and the post-reset write arm flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_INIT;
            row_q   <= '0;
            arm_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            arm_q   <= 1'b1;
        end
    end

endmodule

// File: rtl/col_engine_param.sv
// Column engine: owns one mesh column and drives the external solver.
// Sequencing lives in col_row_sequencer; datapath and probe live here.
module col_engine_param
    import col_engine_pkg::*;
#(
    parameter int DW    = 18,
    parameter int R     = 30,
    parameter int AW    = $clog2(R),
    parameter int PROBE = R / 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          init_req,
    input  logic          step_go,
    output logic [AW-1:0] init_addr,
    input  logic [DW-1:0] init_data,
    input  logic [DW-1:0] left_in,
    input  logic [DW-1:0] right_in,
    output logic [DW-1:0] me,
    output logic [AW-1:0] row_idx,
    output logic [DW-1:0] sol_up,
    output logic [DW-1:0] sol_down,
    output logic [DW-1:0] sol_left,
    output logic [DW-1:0] sol_right,
    output logic [DW-1:0] sol_in,
    output logic [DW-1:0] sol_prev,
    input  logic [DW-1:0] sol_next,
    output logic [AW-1:0] cur_raddr,
    output logic [AW-1:0] cur_waddr,
    output logic [AW-1:0] prev_raddr,
    output logic [AW-1:0] prev_waddr,
    input  logic [DW-1:0] cur_rdata,
    input  logic [DW-1:0] prev_rdata,
    output logic          cur_we,
    output logic          prev_we,
    output logic [DW-1:0] cur_wdata,
    output logic [DW-1:0] prev_wdata,
    output logic          busy,
    output logic          init_done,
    output logic          step_done,
    output logic          probe_valid,
    output logic [DW-1:0] probe_out
);

    localparam int ROW_TOP = R - 1;

    state_t        state;
    logic [AW-1:0] row;
    logic          init_wr;
    logic [DW-1:0] u_in_q, u_down_q, probe_q;
    logic          prime_q, probe_valid_q, init_done_q;
    logic          in_read, in_comp, at_top, at_bot, at_probe;
    logic [AW-1:0] row_nx;

    col_row_sequencer #(.R(R), .AW(AW)) u_seq (
        .clk       (clk),
        .rst       (rst),
        .init_req_i(init_req),
        .step_go_i (step_go),
        .state_o   (state),
        .row_o     (row),
        .init_wr_o (init_wr)
    );

    assign in_read  = state == ST_READ;
    assign in_comp  = state == ST_COMPUTE;
    assign at_top   = int'(row) == ROW_TOP;
    assign at_bot   = int'(row) == ROW_BOTTOM;
    assign at_probe = int'(row) == PROBE;
    assign row_nx   = AW'(wrap_next(int'(row), ROW_TOP));

    // Status, pulses and addresses derived from state and row.
    always_comb begin
        me          = u_in_q;
        row_idx     = row;
        busy        = state != ST_IDLE;
        step_done   = state == ST_DONE;
        init_done   = init_done_q;
        probe_valid = probe_valid_q;
        probe_out   = probe_q;
        init_addr   = (state == ST_INIT) ? row : '0;
        cur_raddr   = (in_read || in_comp) ? row_nx : '0;
        prev_raddr  = (in_read || in_comp) ? row : '0;
    end

    // Solver operand mux and memory write ports.
    always_comb begin
        sol_up     = '0;
        sol_down   = '0;
        sol_left   = '0;
        sol_right  = '0;
        sol_in     = '0;
        sol_prev   = '0;
        cur_we     = 1'b0;
        prev_we    = 1'b0;
        cur_waddr  = '0;
        prev_waddr = '0;
        cur_wdata  = '0;
        prev_wdata = '0;
        if (init_wr) begin
            cur_we     = 1'b1;
            prev_we    = 1'b1;
            cur_waddr  = row;
            prev_waddr = row;
            cur_wdata  = init_data;
            prev_wdata = init_data;
        end else if (in_comp) begin
            sol_up     = at_top ? '0 : cur_rdata;
            sol_down   = at_bot ? '0 : u_down_q;
            sol_left   = left_in;
            sol_right  = right_in;
            sol_in     = u_in_q;
            sol_prev   = prev_rdata;
            cur_we     = 1'b1;
            prev_we    = 1'b1;
            cur_waddr  = row;
            prev_waddr = row;
            cur_wdata  = sol_next;
            prev_wdata = u_in_q;
        end
    end

    // Row pipeline registers: prime latch, u_in/u_down shift.
    always_ff @(posedge clk) begin
        if (rst) begin
            prime_q  <= 1'b0;
            u_in_q   <= '0;
            u_down_q <= '0;
        end else begin
            if (state == ST_PRIME) begin
                prime_q <= 1'b1;
            end else if (in_read) begin
                prime_q <= 1'b0;
            end
            if (in_read && prime_q) begin
                u_in_q <= cur_rdata;
            end else if (in_comp) begin
                u_down_q <= u_in_q;
                u_in_q   <= cur_rdata;
            end
        end
    end

    // Probe capture and the registered done/valid pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            probe_q       <= '0;
            probe_valid_q <= 1'b0;
            init_done_q   <= 1'b0;
        end else begin
            probe_valid_q <= in_comp && at_probe;
            init_done_q   <= init_wr && at_top;
            if (in_comp && at_probe) begin
                probe_q <= sol_next;
            end
        end
    end

endmodule

// File: tb/tb_col_engine_param.sv
// Directed bench for col_engine_param with R=4, PROBE=2.
// Behavioural M10K models and an up+in+down solver stub.
module tb_col_engine_param;

    localparam int DW = 18;
    localparam int R  = 4;
    localparam int AW = 2;

    logic          clk, rst, init_req, step_go;
    logic [AW-1:0] init_addr, row_idx;
    logic [DW-1:0] init_data, left_in, right_in, me;
    logic [DW-1:0] sol_up, sol_down, sol_left, sol_right;
    logic [DW-1:0] sol_in, sol_prev, sol_next;
    logic [AW-1:0] cur_raddr, cur_waddr, prev_raddr, prev_waddr;
    logic [DW-1:0] cur_rdata, prev_rdata, cur_wdata, prev_wdata;
    logic          cur_we, prev_we, busy;
    logic          init_done, step_done, probe_valid;
    logic [DW-1:0] probe_out;

    logic [DW-1:0] cur_mem  [0:R-1];
    logic [DW-1:0] prev_mem [0:R-1];

    int errors = 0;
    int checks = 0;
    int n_id = 0, n_sd = 0, n_cw = 0, n_pw = 0, n_pv = 0;

    typedef struct {
        int row;
        int up;
        int down;
        int in_v;
        int nxt;
    } vec_t;

    vec_t tbl [4];
    int exp_init [4];
    int exp_step [4];

    col_engine_param #(.DW(DW), .R(R), .AW(AW), .PROBE(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .init_req   (init_req),
        .step_go    (step_go),
        .init_addr  (init_addr),
        .init_data  (init_data),
        .left_in    (left_in),
        .right_in   (right_in),
        .me         (me),
        .row_idx    (row_idx),
        .sol_up     (sol_up),
        .sol_down   (sol_down),
        .sol_left   (sol_left),
        .sol_right  (sol_right),
        .sol_in     (sol_in),
        .sol_prev   (sol_prev),
        .sol_next   (sol_next),
        .cur_raddr  (cur_raddr),
        .cur_waddr  (cur_waddr),
        .prev_raddr (prev_raddr),
        .prev_waddr (prev_waddr),
        .cur_rdata  (cur_rdata),
        .prev_rdata (prev_rdata),
        .cur_we     (cur_we),
        .prev_we    (prev_we),
        .cur_wdata  (cur_wdata),
        .prev_wdata (prev_wdata),
        .busy       (busy),
        .init_done  (init_done),
        .step_done  (step_done),
        .probe_valid(probe_valid),
        .probe_out  (probe_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign init_data = DW'(100 * (int'(init_addr) + 1));
    assign sol_next  = sol_in + sol_up + sol_down;

    always @(posedge clk) begin
        if (cur_we) cur_mem[cur_waddr] <= cur_wdata;
        if (prev_we) prev_mem[prev_waddr] <= prev_wdata;
        cur_rdata  <= cur_mem[cur_raddr];
        prev_rdata <= prev_mem[prev_raddr];
    end

    always @(negedge clk) begin
        if (init_done) n_id++;
        if (step_done) n_sd++;
        if (cur_we) n_cw++;
        if (prev_we) n_pw++;
        if (probe_valid) n_pv++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic wait_init(input string tag);
        int n;
        n = 0;
        while (init_done !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_init_done"}, int'(init_done), 1);
        chk({tag, "_init_lat"}, n, 4);
    endtask

    task automatic chk_mem(input string tag, input bit stepped);
        for (int i = 0; i < R; i++) begin
            chk($sformatf("%s_cur%0d", tag, i),
                int'($signed(cur_mem[i])),
                stepped ? exp_step[i] : exp_init[i]);
            chk($sformatf("%s_prev%0d", tag, i),
                int'($signed(prev_mem[i])), exp_init[i]);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_cur_we"}, int'(cur_we), 0);
        chk({tag, "_prev_we"}, int'(prev_we), 0);
        chk({tag, "_init_done"}, int'(init_done), 0);
        chk({tag, "_step_done"}, int'(step_done), 0);
        chk({tag, "_probe_valid"}, int'(probe_valid), 0);
        chk({tag, "_probe_out"}, int'(probe_out), 0);
        chk({tag, "_me"}, int'(me), 0);
        chk({tag, "_busy"}, int'(busy), 1);
        chk({tag, "_row"}, int'(row_idx), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int id0, sd0, cw0, pw0, pv0, first_sd;
        tbl[0] = '{0, 200,   0, 100, 300};
        tbl[1] = '{1, 300, 100, 200, 600};
        tbl[2] = '{2, 400, 200, 300, 900};
        tbl[3] = '{3,   0, 300, 400, 700};
        exp_init = '{100, 200, 300, 400};
        exp_step = '{300, 600, 900, 700};

        rst = 1'b1;
        init_req = 1'b0;
        step_go = 1'b0;
        left_in = '0;
        right_in = '0;
        tick();
        tick();
        chk_quiet("reset");

        id0 = n_id;
        rst = 1'b0;
        tick();
        chk("init_we_row0", int'(cur_we), 1);
        chk("init_addr0", int'(init_addr), 0);
        wait_init("boot");
        tick();
        chk("init_done_pulse", int'(init_done), 0);
        chk("init_done_count", n_id - id0, 1);
        chk_mem("boot", 1'b0);

        sd0 = n_sd;
        cw0 = n_cw;
        pw0 = n_pw;
        pv0 = n_pv;
        first_sd = 0;
        step_go = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (k >= 3 && k <= 9 && (k % 2) == 1) begin
                int i;
                i = (k - 3) / 2;
                chk($sformatf("r%0d_row", i), int'(row_idx), tbl[i].row);
                chk($sformatf("r%0d_up", i), int'($signed(sol_up)), tbl[i].up);
                chk($sformatf("r%0d_down", i), int'($signed(sol_down)), tbl[i].down);
                chk($sformatf("r%0d_in", i), int'($signed(sol_in)), tbl[i].in_v);
                chk($sformatf("r%0d_next", i), int'($signed(sol_next)), tbl[i].nxt);
                chk($sformatf("r%0d_cur_we", i), int'(cur_we), 1);
                chk($sformatf("r%0d_prev_we", i), int'(prev_we), 1);
                chk($sformatf("r%0d_waddr", i), int'(cur_waddr), tbl[i].row);
                chk($sformatf("r%0d_pwdata", i), int'($signed(prev_wdata)), tbl[i].in_v);
            end
            if (k == 8) begin
                chk("probe_valid", int'(probe_valid), 1);
                chk("probe_out", int'($signed(probe_out)), 900);
            end
            if (step_done && first_sd == 0) first_sd = k;
            if (k == 10) step_go = 1'b0;
        end
        chk("step_latency", first_sd, 10);
        chk("step_idle_after", int'(busy), 0);
        chk("step_done_count", n_sd - sd0, 1);
        chk("cur_writes", n_cw - cw0, 4);
        chk("prev_writes", n_pw - pw0, 4);
        chk("probe_valid_count", n_pv - pv0, 1);
        chk_mem("step", 1'b1);

        sd0 = n_sd;
        id0 = n_id;
        step_go = 1'b1;
        tick();
        step_go = 1'b0;
        tick();
        tick();
        tick();
        tick();
        chk("abort_row1", int'(row_idx), 1);
        init_req = 1'b1;
        tick();
        init_req = 1'b0;
        chk("abort_row0", int'(row_idx), 0);
        chk("abort_init_we", int'(cur_we), 1);
        chk("abort_no_done", int'(step_done), 0);
        wait_init("abort");
        tick();
        chk("abort_sd_count", n_sd - sd0, 0);
        chk("abort_id_count", n_id - id0, 1);
        chk_mem("abort", 1'b0);

        sd0 = n_sd;
        init_req = 1'b1;
        step_go = 1'b1;
        tick();
        init_req = 1'b0;
        step_go = 1'b0;
        chk("both_init_we", int'(cur_we), 1);
        chk("both_init_addr", int'(init_addr), 0);
        wait_init("both");
        tick();
        tick();
        chk("both_idle", int'(busy), 0);
        chk("both_sd_count", n_sd - sd0, 0);

        step_go = 1'b1;
        tick();
        step_go = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_quiet("rst_read");
        tick();
        chk("rst_read_init_we", int'(cur_we), 1);
        wait_init("rst_read");
        tick();
        chk_mem("rst_read", 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
